// File: rtl/trig_record_reader.sv
// rtl/trig_record_reader.sv - trigger record FIFO and framed byte-stream reader
module trig_record_reader #(
    parameter int          DEPTH = 8,
    parameter int          AW    = 3,
    parameter logic [7:0]  HDR   = 8'hA5
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            rec_valid,
    input  logic [55:0]     rec_time,
    input  logic [7:0]      rec_bits,
    input  logic            flush,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [AW:0]     fifo_count,
    output logic [15:0]     overflow_cnt,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BITS,
        S_TS,
        S_CSUM
    } state_t;

    localparam logic [AW:0]   FULL_C    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   ovf_q, ovf_d;

    state_t        state_q, state_d;
    logic [2:0]    ts_idx_q, ts_idx_d;
    logic [55:0]   sh_time_q, sh_time_d;
    logic [7:0]    sh_bits_q, sh_bits_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;

    logic          push_req, push_ok, drop, pop, full, hs;
    logic [63:0]   head;
    logic [7:0]    csum;
    logic [2:0]    ts_idx_m1;
    logic [5:0]    ts_lsb;

    // Records with an empty bitstring are not real triggers; a flush edge also swallows the push.
    assign push_req  = rec_valid && (rec_bits != 8'h00) && !flush;
    assign full      = (count_q == FULL_C);
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && !push_ok;
    assign head      = mem_q[rd_ptr_q];
    assign hs        = tx_valid_q && tx_ready;
    assign ts_idx_m1 = ts_idx_q - 3'd1;
    assign ts_lsb    = {ts_idx_m1, 3'b000};

    always_comb begin
        csum = sh_bits_q;
        for (int i = 0; i < 7; i++) begin
            csum = csum ^ sh_time_q[i*8 +: 8];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!push_ok && pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {rec_time, rec_bits};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Output bytes are preloaded one state ahead so tx_data is always a register.
    always_comb begin
        state_d    = state_q;
        ts_idx_d   = ts_idx_q;
        sh_time_d  = sh_time_q;
        sh_bits_d  = sh_bits_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d    = S_HDR;
                    sh_time_d  = head[63:8];
                    sh_bits_d  = head[7:0];
                    tx_data_d  = HDR;
                    tx_valid_d = 1'b1;
                end
            end
            S_HDR: begin
                if (hs) begin
                    state_d   = S_BITS;
                    tx_data_d = sh_bits_q;
                end
            end
            S_BITS: begin
                if (hs) begin
                    state_d   = S_TS;
                    ts_idx_d  = 3'd6;
                    tx_data_d = sh_time_q[55:48];
                end
            end
            S_TS: begin
                if (hs) begin
                    if (ts_idx_q == 3'd0) begin
                        state_d   = S_CSUM;
                        tx_data_d = csum;
                    end else begin
                        ts_idx_d  = ts_idx_m1;
                        tx_data_d = sh_time_q[ts_lsb +: 8];
                    end
                end
            end
            S_CSUM: begin
                if (hs) begin
                    state_d    = S_IDLE;
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            ts_idx_q   <= 3'd0;
            sh_time_q  <= '0;
            sh_bits_q  <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_idx_q   <= ts_idx_d;
            sh_time_q  <= sh_time_d;
            sh_bits_q  <= sh_bits_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign fifo_count   = count_q;
    assign overflow_cnt = ovf_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_trig_record_reader.sv
// tb/tb_trig_record_reader.sv - directed self-checking bench for trig_record_reader
module tb_trig_record_reader;

    logic        clk;
    logic        nrst;
    logic        rec_valid;
    logic [55:0] rec_time;
    logic [7:0]  rec_bits;
    logic        flush;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  fifo_count;
    logic [15:0] overflow_cnt;
    logic        busy;

    int n_cmp;
    int n_bad;
    logic [7:0] got[$];
    int busy_cycles;
    int unstable;

    trig_record_reader #(.DEPTH(8), .AW(3), .HDR(8'hA5)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .rec_valid    (rec_valid),
        .rec_time     (rec_time),
        .rec_bits     (rec_bits),
        .flush        (flush),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .fifo_count   (fifo_count),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] rec_t(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {b, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, b ^ 8'h5A};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [55:0] t, input logic [7:0] b, input int i);
        logic [7:0] c;
        c = b;
        for (int j = 0; j < 7; j++) c = c ^ t[j*8 +: 8];
        if (i == 0) return 8'hA5;
        if (i == 1) return b;
        if (i == 9) return c;
        return t[(8-i)*8 +: 8];
    endfunction

    task automatic push(input logic [55:0] t, input logic [7:0] b);
        rec_valid = 1'b1;
        rec_time  = t;
        rec_bits  = b;
        tick();
        rec_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int max_cyc, input bit toggle,
                           input int flush_at, input int rst_at);
        logic [7:0] held;
        bit holding;
        bit flushed;
        bit rdy;
        got.delete();
        busy_cycles = 0;
        unstable    = 0;
        holding     = 0;
        flushed     = 0;
        for (int c = 0; c < max_cyc && got.size() < n; c++) begin
            rdy = toggle ? ((c % 2) == 0) : 1'b1;
            tx_ready = rdy;
            if (holding && (!tx_valid || tx_data !== held)) unstable++;
            holding = 0;
            if (busy) busy_cycles++;
            if (rst_at >= 0 && got.size() == rst_at) begin
                nrst = 1'b0;
                tick();
                tx_ready = 1'b0;
                return;
            end
            if (flush_at >= 0 && got.size() == flush_at && !flushed) begin
                flush   = 1'b1;
                flushed = 1;
            end
            if (tx_valid && rdy) got.push_back(tx_data);
            else if (tx_valid) begin
                holding = 1;
                held    = tx_data;
            end
            tick();
            flush = 1'b0;
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (overflow_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_ovf got=%0d exp=0", overflow_cnt); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [10];
        exp = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23, 8'h23};
        push(56'h123, 8'h01);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL t1_valid_after_push got=%b exp=0", tx_valid); end
        n_cmp++; if (fifo_count !== 4'd1) begin n_bad++; $display("FAIL t1_count_after_push got=%0d exp=1", fifo_count); end
        tick();
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin n_bad++; $display("FAIL t1_hdr_latency got=%b/%h exp=1/a5", tx_valid, tx_data); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL t1_count_after_pop got=%0d exp=0", fifo_count); end
        collect(10, 40, 0, -1, -1);
        n_cmp++; if (got.size() != 10) begin n_bad++; $display("FAIL t1_len got=%0d exp=10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g;
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_cmp++; if (g !== exp[i]) begin n_bad++; $display("FAIL t1_byte%0d got=%h exp=%h", i, g, exp[i]); end
        end
        n_cmp++; if (busy_cycles != 10) begin n_bad++; $display("FAIL t1_busy_cycles got=%0d exp=10", busy_cycles); end
        n_cmp++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL t1_idle_gap got=%b/%b exp=0/0", busy, tx_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [10];
        exp = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23, 8'h23};
        push(56'h123, 8'h01);
        collect(10, 60, 1, -1, -1);
        n_cmp++; if (got.size() != 10) begin n_bad++; $display("FAIL t2_len got=%0d exp=10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g;
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_cmp++; if (g !== exp[i]) begin n_bad++; $display("FAIL t2_byte%0d got=%h exp=%h", i, g, exp[i]); end
        end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL t2_hold_stable got=%0d exp=0", unstable); end
        tick();
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 11; k++) push(rec_t(k), k[7:0]);
        n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL t3_count got=%0d exp=8", fifo_count); end
        n_cmp++; if (overflow_cnt !== 16'd2) begin n_bad++; $display("FAIL t3_ovf got=%0d exp=2", overflow_cnt); end
        collect(90, 400, 0, -1, -1);
        n_cmp++; if (got.size() != 90) begin n_bad++; $display("FAIL t3_len got=%0d exp=90", got.size()); end
        for (int i = 0; i < 90; i++) begin
            int k;
            logic [7:0] g, e;
            k = i / 10 + 1;
            g = (i < got.size()) ? got[i] : 8'hxx;
            e = exp_byte(rec_t(k), k[7:0], i % 10);
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL t3_byte%0d got=%h exp=%h", i, g, e); end
        end
        for (int c = 0; c < 15; c++) begin
            tx_ready = 1'b1;
            tick();
        end
        tx_ready = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0 || fifo_count !== 4'd0) begin n_bad++; $display("FAIL t3_drained got=%b/%0d exp=0/0", tx_valid, fifo_count); end
    endtask

    task automatic test_full_push_at_pop();
        for (int k = 20; k <= 28; k++) push(rec_t(k), k[7:0]);
        n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL t4_full got=%0d exp=8", fifo_count); end
        collect(10, 40, 0, -1, -1);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g, e;
            g = (i < got.size()) ? got[i] : 8'hxx;
            e = exp_byte(rec_t(20), 8'd20, i);
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL t4_first_byte%0d got=%h exp=%h", i, g, e); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t4_idle_before_pop got=%b exp=0", busy); end
        push(rec_t(29), 8'd29);
        n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL t4_count_kept got=%0d exp=8", fifo_count); end
        n_cmp++; if (overflow_cnt !== 16'd2) begin n_bad++; $display("FAIL t4_ovf_kept got=%0d exp=2", overflow_cnt); end
        collect(90, 400, 0, -1, -1);
        n_cmp++; if (got.size() != 90) begin n_bad++; $display("FAIL t4_len got=%0d exp=90", got.size()); end
        for (int i = 0; i < 90; i++) begin
            int k;
            logic [7:0] g, e;
            k = i / 10 + 21;
            g = (i < got.size()) ? got[i] : 8'hxx;
            e = exp_byte(rec_t(k), k[7:0], i % 10);
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL t4_byte%0d got=%h exp=%h", i, g, e); end
        end
        tick();
    endtask

    task automatic test_flush();
        int seen;
        for (int k = 40; k <= 42; k++) push(rec_t(k), k[7:0]);
        collect(10, 40, 0, 3, -1);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g, e;
            g = (i < got.size()) ? got[i] : 8'hxx;
            e = exp_byte(rec_t(40), 8'd40, i);
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL t5_byte%0d got=%h exp=%h", i, g, e); end
        end
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tx_ready = 1'b1;
            if (tx_valid) seen++;
            tick();
        end
        tx_ready = 1'b0;
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL t5_no_more_frames got=%0d exp=0", seen); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL t5_count got=%0d exp=0", fifo_count); end
        flush = 1'b1;
        push(rec_t(43), 8'd43);
        flush = 1'b0;
        n_cmp++; if (fifo_count !== 4'd0 || overflow_cnt !== 16'd2) begin n_bad++; $display("FAIL t5_push_with_flush got=%0d/%0d exp=0/2", fifo_count, overflow_cnt); end
        tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL t5_push_with_flush_out got=%b exp=0", tx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        push(rec_t(50), 8'd50);
        push(rec_t(51), 8'd51);
        collect(20, 60, 0, -1, 4);
        n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL t6_abort got=%b/%b exp=0/0", tx_valid, busy); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL t6_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (overflow_cnt !== 16'd0) begin n_bad++; $display("FAIL t6_ovf got=%0d exp=0", overflow_cnt); end
        nrst = 1'b1;
        tick();
        push(rec_t(52), 8'd52);
        collect(10, 40, 0, -1, -1);
        n_cmp++; if (got.size() != 10) begin n_bad++; $display("FAIL t6_len got=%0d exp=10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g, e;
            g = (i < got.size()) ? got[i] : 8'hxx;
            e = exp_byte(rec_t(52), 8'd52, i);
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL t6_byte%0d got=%h exp=%h", i, g, e); end
        end
        tick();
    endtask

    task automatic test_zero_bits();
        int seen;
        seen = 0;
        for (int c = 0; c < 4; c++) push(rec_t(60 + c), 8'h00);
        for (int c = 0; c < 6; c++) begin
            tx_ready = 1'b1;
            if (tx_valid) seen++;
            tick();
        end
        tx_ready = 1'b0;
        n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL t7_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (overflow_cnt !== 16'd0) begin n_bad++; $display("FAIL t7_ovf got=%0d exp=0", overflow_cnt); end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL t7_no_output got=%0d exp=0", seen); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        nrst      = 1'b0;
        rec_valid = 1'b0;
        rec_time  = '0;
        rec_bits  = '0;
        flush     = 1'b0;
        tx_ready  = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overflow();
        test_full_push_at_pop();
        test_flush();
        test_reset_mid_frame();
        test_zero_bits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
